axi_sram_responder: RTL and testbench
=====================================

// Module: axi_sram_responder
// PURPOSE
//  AXI3 slave that ends the CPU's external AXI master port (the crossbar output) and answers it from an internal word-addressed SRAM.
//  It is the memory-side bench and FPGA target for the dcache and instruction-fetch masters. It serves one transaction at a time (read or write).
// PARAMETERS
//  MEM_AW   12   log2 of memory depth in 32-bit words; address bits [MEM_AW+1:2] index memory, upper bits alias
//  INIT_HEX ""   optional $readmemh image loaded at time 0; empty means memory is uninitialised
// PORTS
//  aclk     in   1   clock; all logic on rising edge
//  aresetn  in   1   asynchronous active-low reset
//  awid     in   4   write ID, returned on bid
//  awaddr   in   32  write start byte address; bits [1:0] ignored
//  awlen    in   4   write beats minus one
//  awburst  in   2   00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  awvalid  in   1   write address valid
//  awready  out  1   write address accepted
//  wdata    in   32  write data
//  wstrb    in   4   byte enables; bit i writes byte i
//  wlast    in   1   master's last-beat marker
//  wvalid   in   1   write data valid
//  wready   out  1   write data accepted
//  bid      out  4   latched awid
//  bresp    out  2   00 OKAY, 10 SLVERR
//  bvalid   out  1   write response valid
//  bready   in   1   write response accepted
//  arid     in   4   read ID, returned on rid
//  araddr   in   32  read start byte address; bits [1:0] ignored
//  arlen    in   4   read beats minus one
//  arburst  in   2   same encoding as awburst
//  arvalid  in   1   read address valid
//  arready  out  1   read address accepted
//  rid      out  4   latched arid
//  rdata    out  32  read data
//  rresp    out  2   00 OKAY, 10 SLVERR
//  rlast    out  1   high on final read beat
//  rvalid   out  1   read data valid
//  rready   in   1   read data accepted
// BEHAVIOUR
//  Only 32-bit beats (size 2) are supported; the top ties size off. lock, cache, prot and wid are not ports.
//  While aresetn is low, every output is 0 and the FSM is IDLE. Memory contents are never reset.
//  FSM: IDLE -> WDATA -> WRESP -> IDLE, or IDLE -> RADDR -> RDATA -> IDLE.
//   Reset mid-burst aborts the burst. Beats already written stay in memory.
//  IDLE: awready = awvalid-grant and arready = arvalid-grant, both combinational and only in IDLE.
//   If awvalid and arvalid are both high, a 1-bit priority flag (reset = read first) picks the winner and then toggles.
//   On handshake, latch id, addr[31:2], len and burst, clear beat counter; go to WDATA or RADDR.
//  Beat address step, applied after each beat:
//   FIXED: unchanged.
//   INCR: +1 word, wrapping modulo 2^30.
//   WRAP: +1 word inside a (len+1)-word aligned window; low log2(len+1) bits wrap.
//   WRAP with len not in {1,3,7,15}, or burst 11: reserved. Every beat answers SLVERR, no memory write, reads return 0.
//  WDATA: wready = 1. On each wvalid&wready, write bytes enabled by wstrb to mem[addr] and advance the counter.
//   On beat (len), go to WRESP. bresp = SLVERR if wlast differed from (count==len) on any beat, or burst reserved; else OKAY.
//  WRESP: bvalid = 1 and bid = latched id, held stable until bready. bvalid&bready -> IDLE.
//  RADDR: one cycle to issue the synchronous SRAM read. RDATA: rvalid = 1.
//   Latency: AR handshake in cycle T gives first rvalid in T+2.
//   With rready held high, beats go back-to-back at one per cycle (read-ahead of next address).
//   While rready is low, rdata, rid, rresp and rlast are held stable.
//   rlast = (count==len). rvalid&rready&rlast -> IDLE. Memory output is not valid until the cycle after RADDR.
//  The FSM never accepts a new AW/AR until B or the last R handshake completes. Only one transaction is outstanding.
// TESTING
//  Write INCR addr 0x100, len 3, data 11,22,33,44, wstrb F -> one bvalid with bresp 00, bid=awid. Read back gives 11,22,33,44, rlast on beat 3 only.
//  WRAP read araddr 0x108, len 3 after the above -> rdata 33,44,11,22; rvalid at T+2 after AR handshake.
//  awvalid and arvalid high in the same cycle after reset -> AR granted first. Next simultaneous pair -> AW granted first.
//  Write 0xAABBCCDD with wstrb 0101 over 0 -> read returns 0x00BB00DD. Read len 7 with rready toggling 1,0,0,1 -> data held stable, no beat lost.
//  Write len 3 with wlast asserted on beat 1 -> 4 beats accepted, bresp 10. Burst 11 read -> 16 beats only if len=15, all rresp 10 and data 0.
//  aresetn low during beat 2 of an 8-beat read -> rvalid 0 immediately. After release, IDLE with arready=1 for a new arvalid.

Source files
------------

// File: rtl/axi_sram_responder.sv
// AXI3 slave answering one read or write burst at a time from an internal
// word-addressed SRAM. 32-bit beats only; FIXED/INCR/WRAP bursts.
module axi_sram_responder #(
  parameter int unsigned MEM_AW   = 12,
  parameter string       INIT_HEX = ""
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int unsigned DEPTH       = 2 ** MEM_AW;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WRESP,
    S_RADDR,
    S_RDATA
  } state_t;

  // Reserved encodings: burst 11, or WRAP whose length is not a power of two.
  function automatic logic burst_reserved(input logic [1:0] burst, input logic [3:0] len);
    return (burst == 2'b11) ||
           ((burst == BURST_WRAP) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
  endfunction

  logic [31:0]       mem [DEPTH];
  state_t            state;
  logic              prio_rd;
  logic [29:0]       addr_q;
  logic [3:0]        len_q;
  logic [3:0]        cnt_q;
  logic [1:0]        burst_q;
  logic              rsv_q;
  logic              werr_q;

  logic              ar_win_c;
  logic              aw_win_c;
  logic [29:0]       next_addr_c;
  logic [29:0]       wrap_mask_c;
  logic [MEM_AW-1:0] mem_idx_c;
  logic              last_beat_c;
  logic              wr_err_c;
  logic              mem_we_c;
  logic [3:0]        cnt_inc_c;
  logic              unused_addr_lsb;

  // Address grants: only in IDLE; on contention the priority flag picks.
  assign ar_win_c = arvalid & (~awvalid | prio_rd);
  assign aw_win_c = awvalid & (~arvalid | ~prio_rd);
  assign arready  = aresetn & (state == S_IDLE) & ar_win_c;
  assign awready  = aresetn & (state == S_IDLE) & aw_win_c;

  assign mem_idx_c       = addr_q[MEM_AW-1:0];
  assign last_beat_c     = (cnt_q == len_q);
  assign cnt_inc_c       = 4'(cnt_q + 4'd1);
  assign wr_err_c        = werr_q | (wlast != last_beat_c);
  assign mem_we_c        = (state == S_WDATA) & wvalid & ~rsv_q;
  assign wrap_mask_c     = {26'd0, len_q};
  assign unused_addr_lsb = ^{awaddr[1:0], araddr[1:0]};

  // Word address of the following beat.
  always_comb begin
    next_addr_c = addr_q;
    case (burst_q)
      BURST_INCR: next_addr_c = 30'(addr_q + 30'd1);
      BURST_WRAP: next_addr_c = (addr_q & ~wrap_mask_c) |
                                (30'(addr_q + 30'd1) & wrap_mask_c);
      default:    next_addr_c = addr_q;
    endcase
  end

  // Byte-enabled SRAM write port; contents survive reset.
  always_ff @(posedge aclk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[mem_idx_c][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Transaction FSM with registered channel outputs and synchronous SRAM read.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= S_IDLE;
      prio_rd <= 1'b1;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      rsv_q   <= 1'b0;
      werr_q  <= 1'b0;
      wready  <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
      bvalid  <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rlast   <= 1'b0;
      rvalid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arvalid && arready) begin
            if (awvalid) prio_rd <= ~prio_rd;
            rid     <= arid;
            addr_q  <= araddr[31:2];
            len_q   <= arlen;
            burst_q <= arburst;
            rsv_q   <= burst_reserved(arburst, arlen);
            cnt_q   <= '0;
            state   <= S_RADDR;
          end else if (awvalid && awready) begin
            if (arvalid) prio_rd <= ~prio_rd;
            bid     <= awid;
            addr_q  <= awaddr[31:2];
            len_q   <= awlen;
            burst_q <= awburst;
            rsv_q   <= burst_reserved(awburst, awlen);
            cnt_q   <= '0;
            werr_q  <= 1'b0;
            wready  <= 1'b1;
            state   <= S_WDATA;
          end
        end
        S_WDATA: begin
          if (wvalid) begin
            cnt_q  <= cnt_inc_c;
            addr_q <= next_addr_c;
            werr_q <= wr_err_c;
            if (last_beat_c) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bresp  <= (wr_err_c || rsv_q) ? RESP_SLVERR : RESP_OKAY;
              state  <= S_WRESP;
            end
          end
        end
        S_WRESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
            state  <= S_IDLE;
          end
        end
        S_RADDR: begin
          rdata  <= rsv_q ? 32'd0 : mem[mem_idx_c];
          rresp  <= rsv_q ? RESP_SLVERR : RESP_OKAY;
          rlast  <= last_beat_c;
          rvalid <= 1'b1;
          addr_q <= next_addr_c;
          state  <= S_RDATA;
        end
        S_RDATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid <= 1'b0;
              rlast  <= 1'b0;
              state  <= S_IDLE;
            end else begin
              cnt_q  <= cnt_inc_c;
              rdata  <= rsv_q ? 32'd0 : mem[mem_idx_c];
              rlast  <= (cnt_inc_c == len_q);
              addr_q <= next_addr_c;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Testbench for axi_sram_responder: directed corner sequences, a vector table
// and randomized bursts checked against a word-array memory model.
module tb_axi_sram_responder;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [3:0]  awlen = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [3:0]  arlen = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  always #5 aclk = ~aclk;

  axi_sram_responder #(.MEM_AW(12)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [4096];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic        rpat [4];
  int          rpat_n = 1;
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id;

  typedef struct {
    bit          is_wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  burst;
    int          lastbeat;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    int          exp_beats;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  function automatic logic is_rsv(input logic [1:0] b, input logic [3:0] len);
    return (b == 2'b11) || (b == 2'b10 && len != 4'd1 && len != 4'd3 && len != 4'd7 && len != 4'd15);
  endfunction

  // Word index of beat i, from the burst definitions.
  function automatic logic [11:0] beat_idx(input logic [31:0] addr, input logic [3:0] len,
                                           input logic [1:0] b, input int i);
    int unsigned w, n, base;
    w = addr >> 2;
    n = int'(len) + 1;
    if (b == 2'b00) return 12'(w);
    if (b == 2'b01) return 12'(w + i);
    base = w - (w % n);
    return 12'(base + ((w - base + i) % n));
  endfunction

  task automatic set_rpat_all1();
    rpat[0] = 1'b1;
    rpat_n  = 1;
  endtask

  task automatic aw_hs(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [1:0] b);
    int n;
    awid = id; awaddr = addr; awlen = len; awburst = b; awvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!awready && n < 50) begin n++; @(negedge aclk); end
    if (!awready) fail_now("aw_handshake");
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_collect(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] b,
                           input int lastbeat, input int bwait,
                           output logic [3:0] got_bid, output logic [1:0] got_bresp,
                           output int beats);
    int n;
    logic [11:0] idx;
    beats = 0;
    got_bid = '0;
    got_bresp = '0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == lastbeat); wvalid = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!wready && n < 50) begin n++; @(negedge aclk); end
      if (!wready) begin
        fail_now("w_handshake");
        wvalid = 1'b0;
        return;
      end
      @(posedge aclk); #1;
      beats++;
      if (!is_rsv(b, len)) begin
        idx = beat_idx(addr, len, b, i);
        for (int k = 0; k < 4; k++)
          if (ws[i][k]) mdl[idx][8*k +: 8] = wd[i][8*k +: 8];
      end
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    repeat (bwait) @(posedge aclk);
    #1;
    bready = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!bvalid && n < 50) begin n++; @(negedge aclk); end
    if (!bvalid) fail_now("b_handshake");
    got_bid = bid;
    got_bresp = bresp;
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                    input logic [1:0] b, input int lastbeat, input int bwait,
                    output logic [3:0] got_bid, output logic [1:0] got_bresp, output int beats);
    aw_hs(id, addr, len, b);
    w_collect(addr, len, b, lastbeat, bwait, got_bid, got_bresp, beats);
  endtask

  task automatic ar_hs(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [1:0] b);
    int n;
    arid = id; araddr = addr; arlen = len; arburst = b; arvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!arready && n < 50) begin n++; @(negedge aclk); end
    if (!arready) fail_now("ar_handshake");
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  // Collects read beats following rpat; checks held outputs while stalled.
  task automatic r_collect(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] b, input bit vs_model,
                           output int beats, output int lat);
    int cyc;
    bit done, held;
    logic [31:0] h_data;
    logic [1:0]  h_resp;
    logic        h_last;
    logic [3:0]  h_id;
    logic [31:0] exp_d;
    beats = 0; lat = -1; cyc = 0; done = 1'b0; held = 1'b0;
    h_data = '0; h_resp = '0; h_last = 1'b0; h_id = '0; rd_id = '0;
    while (!done && cyc < 200 && beats < 16) begin
      rready = rpat[cyc % rpat_n];
      @(negedge aclk);
      if (rvalid && lat < 0) lat = cyc + 1;
      if (held) begin
        chk("r_hold_data", rdata, h_data);
        chk("r_hold_ctl", 32'({rresp, rlast, rid}), 32'({h_resp, h_last, h_id}));
        held = 1'b0;
      end
      if (rvalid && rready) begin
        rd_data[beats] = rdata; rd_resp[beats] = rresp; rd_last[beats] = rlast;
        if (beats == 0) rd_id = rid;
        if (rlast) done = 1'b1;
        beats++;
      end else if (rvalid) begin
        held = 1'b1;
        h_data = rdata; h_resp = rresp; h_last = rlast; h_id = rid;
      end
      @(posedge aclk); #1;
      cyc++;
    end
    rready = 1'b0;
    if (!done) fail_now("r_last");
    if (vs_model) begin
      chk("r_beats", 32'(beats), 32'(int'(len) + 1));
      chk("r_id", 32'(rd_id), 32'(id));
      for (int i = 0; i < beats; i++) begin
        exp_d = is_rsv(b, len) ? 32'd0 : mdl[beat_idx(addr, len, b, i)];
        chk("r_data", rd_data[i], exp_d);
        chk("r_resp", 32'(rd_resp[i]), is_rsv(b, len) ? 32'd2 : 32'd0);
        chk("r_last", 32'(rd_last[i]), 32'(i == int'(len)));
      end
    end
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                    input logic [1:0] b, input bit vs_model, output int beats, output int lat);
    ar_hs(id, addr, len, b);
    r_collect(id, addr, len, b, vs_model, beats, lat);
  endtask

  initial begin
    logic [3:0]  g_bid;
    logic [1:0]  g_bresp;
    int          beats, lat, acc, n;
    logic [3:0]  len;
    logic [1:0]  b;
    logic [31:0] addr;
    int unsigned word;

    tbl[0] = '{1'b1, 4'h1, 32'h040, 4'd3, 2'b01, 3, 4'hF, 2'b00, 4};
    tbl[1] = '{1'b0, 4'h2, 32'h040, 4'd3, 2'b01, 3, 4'hF, 2'b00, 4};
    tbl[2] = '{1'b1, 4'h3, 32'h080, 4'd7, 2'b10, 7, 4'hF, 2'b00, 8};
    tbl[3] = '{1'b0, 4'h4, 32'h094, 4'd7, 2'b10, 7, 4'hF, 2'b00, 8};
    tbl[4] = '{1'b1, 4'h5, 32'h0C0, 4'd2, 2'b10, 2, 4'hF, 2'b10, 3};
    tbl[5] = '{1'b0, 4'h6, 32'h0C0, 4'd2, 2'b10, 2, 4'hF, 2'b10, 3};
    tbl[6] = '{1'b0, 4'h7, 32'h0C0, 4'd1, 2'b01, 1, 4'hF, 2'b00, 2};
    tbl[7] = '{1'b1, 4'h8, 32'h0D0, 4'd2, 2'b00, 2, 4'h3, 2'b00, 3};
    tbl[8] = '{1'b0, 4'h9, 32'h0D0, 4'd0, 2'b00, 0, 4'hF, 2'b00, 1};
    set_rpat_all1();

    // Reset: every output low even with valids asserted
    repeat (3) @(posedge aclk);
    #1;
    awvalid = 1'b1; arvalid = 1'b1;
    #1;
    chk("reset_ctl", 32'({awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid}), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    awvalid = 1'b0; arvalid = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Contention after reset: read first, then write
    arid = 4'hA; araddr = 32'h0; arlen = 4'd0; arburst = 2'b01;
    awid = 4'hB; awaddr = 32'h0; awlen = 4'd0; awburst = 2'b01;
    awvalid = 1'b1; arvalid = 1'b1;
    @(negedge aclk);
    chk("prio1_grant", 32'({arready, awready}), 32'b10);
    @(posedge aclk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    r_collect(4'hA, 32'h0, 4'd0, 2'b01, 1'b0, beats, lat);
    chk("prio1_rid", 32'(rd_id), 32'hA);
    awvalid = 1'b1; arvalid = 1'b1;
    @(negedge aclk);
    chk("prio2_grant", 32'({arready, awready}), 32'b01);
    @(posedge aclk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    wd[0] = 32'h1234_5678; ws[0] = 4'hF;
    w_collect(32'h0, 4'd0, 2'b01, 0, 0, g_bid, g_bresp, beats);
    chk("prio2_b", 32'({g_bid, g_bresp}), 32'({4'hB, 2'b00}));

    // Fill words 0..255 so all later reads hit known data
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      wr(4'h0, 32'(k * 64), 4'd15, 2'b01, 15, 0, g_bid, g_bresp, beats);
      chk("init_bresp", 32'(g_bresp), 32'd0);
    end

    // INCR write then read-back
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    wr(4'h5, 32'h100, 4'd3, 2'b01, 3, 1, g_bid, g_bresp, beats);
    chk("incr_bid", 32'(g_bid), 32'h5);
    chk("incr_bresp", 32'(g_bresp), 32'd0);
    rd(4'h6, 32'h100, 4'd3, 2'b01, 1'b0, beats, lat);
    chk("incr_rd_beats", 32'(beats), 32'd4);
    chk("incr_rd_lat", 32'(lat), 32'd2);
    chk("incr_rd_rid", 32'(rd_id), 32'h6);
    chk("incr_rd_d0", rd_data[0], 32'h11);
    chk("incr_rd_d1", rd_data[1], 32'h22);
    chk("incr_rd_d2", rd_data[2], 32'h33);
    chk("incr_rd_d3", rd_data[3], 32'h44);
    chk("incr_rd_last", 32'({rd_last[0], rd_last[1], rd_last[2], rd_last[3]}), 32'b0001);

    // WRAP read inside the 4-word window
    rd(4'h7, 32'h108, 4'd3, 2'b10, 1'b0, beats, lat);
    chk("wrap_lat", 32'(lat), 32'd2);
    chk("wrap_d0", rd_data[0], 32'h33);
    chk("wrap_d1", rd_data[1], 32'h44);
    chk("wrap_d2", rd_data[2], 32'h11);
    chk("wrap_d3", rd_data[3], 32'h22);

    // Partial byte strobes over zero
    wd[0] = 32'h0; ws[0] = 4'hF;
    wr(4'h1, 32'h200, 4'd0, 2'b01, 0, 0, g_bid, g_bresp, beats);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    wr(4'h1, 32'h200, 4'd0, 2'b01, 0, 0, g_bid, g_bresp, beats);
    rd(4'h2, 32'h200, 4'd0, 2'b01, 1'b0, beats, lat);
    chk("strb_data", rd_data[0], 32'h00BB_00DD);

    // Back-pressured 8-beat read
    rpat[0] = 1'b1; rpat[1] = 1'b0; rpat[2] = 1'b0; rpat[3] = 1'b1; rpat_n = 4;
    rd(4'h3, 32'h100, 4'd7, 2'b01, 1'b1, beats, lat);
    set_rpat_all1();

    // Early wlast: all beats taken, SLVERR
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    wr(4'h4, 32'h140, 4'd3, 2'b01, 1, 0, g_bid, g_bresp, beats);
    chk("early_wlast_beats", 32'(beats), 32'd4);
    chk("early_wlast_bresp", 32'(g_bresp), 32'd2);
    rd(4'h4, 32'h140, 4'd3, 2'b01, 1'b1, beats, lat);

    // Reserved burst read: 16 error beats of zero
    rd(4'hC, 32'h180, 4'd15, 2'b11, 1'b1, beats, lat);
    chk("rsv_beats", 32'(beats), 32'd16);
    chk("rsv_last_resp", 32'(rd_resp[15]), 32'd2);

    // Reset in the middle of an 8-beat read
    ar_hs(4'hD, 32'h100, 4'd7, 2'b01);
    rready = 1'b1; acc = 0; n = 0;
    while (acc < 2 && n < 20) begin
      @(negedge aclk);
      if (rvalid && rready) acc++;
      @(posedge aclk); #1;
      n++;
    end
    chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'({rvalid, rlast}), 32'd0);
    rready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    arid = 4'hE; araddr = 32'h110; arlen = 4'd1; arburst = 2'b01; arvalid = 1'b1;
    #1;
    chk("post_rst_arready", 32'(arready), 32'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    r_collect(4'hE, 32'h110, 4'd1, 2'b01, 1'b1, beats, lat);

    // Vector table
    for (int t = 0; t < 9; t++) begin
      if (tbl[t].is_wr) begin
        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = tbl[t].strb; end
        wr(tbl[t].id, tbl[t].addr, tbl[t].len, tbl[t].burst, tbl[t].lastbeat, 0, g_bid, g_bresp, beats);
        chk("tbl_bresp", 32'(g_bresp), 32'(tbl[t].exp_resp));
        chk("tbl_bid", 32'(g_bid), 32'(tbl[t].id));
      end else begin
        rd(tbl[t].id, tbl[t].addr, tbl[t].len, tbl[t].burst, 1'b1, beats, lat);
        chk("tbl_rresp", 32'(rd_resp[0]), 32'(tbl[t].exp_resp));
      end
      chk("tbl_beats", 32'(beats), 32'(tbl[t].exp_beats));
    end

    // Randomized bursts against the model
    for (int it = 0; it < 40; it++) begin
      b = 2'($urandom_range(0, 2));
      if (b == 2'b10) begin
        case ($urandom_range(0, 3))
          0: len = 4'd1;
          1: len = 4'd3;
          2: len = 4'd7;
          default: len = 4'd15;
        endcase
      end else begin
        len = 4'($urandom_range(0, 15));
      end
      word = $urandom_range(0, 239);
      addr = 32'((word << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        wr(4'($urandom), addr, len, b, int'(len), $urandom_range(0, 2), g_bid, g_bresp, beats);
        chk("rand_bresp", 32'(g_bresp), 32'd0);
      end else begin
        for (int i = 0; i < 4; i++) rpat[i] = 1'($urandom);
        rpat[$urandom_range(0, 3)] = 1'b1;
        rpat_n = 4;
        rd(4'($urandom), addr, len, b, 1'b1, beats, lat);
        chk("rand_lat", 32'(lat), 32'd2);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
